// File: rtl/field_nbr_fetch_if.sv
// Field-buffer select type and the request / RAM-read / result bundle for field_nbr_fetch.
// slave modport is the fetch block; master modport is its environment.
package field_nbr_fetch_pkg;
    typedef enum logic {
        FIELD_A = 1'b0,
        FIELD_B = 1'b1
    } cur_field_t;
endpackage

interface field_nbr_fetch_if #(
    parameter int unsigned FIELD_W = 64,
    parameter int unsigned FIELD_H = 32
) ();
    import field_nbr_fetch_pkg::*;

    localparam int unsigned X_ADR_SIZE     = $clog2(FIELD_W);
    localparam int unsigned Y_ADR_SIZE     = $clog2(FIELD_H);
    localparam int unsigned ADR_SIZE       = $clog2(FIELD_W * FIELD_H);
    localparam int unsigned NEIGHBOURS_CNT = 8;

    logic                      i_req_valid;
    logic                      o_req_ready;
    logic [X_ADR_SIZE-1:0]     i_x;
    logic [Y_ADR_SIZE-1:0]     i_y;
    cur_field_t                i_field;

    logic                      o_rd_en;
    logic [ADR_SIZE-1:0]       o_rd_addr;
    cur_field_t                o_rd_field;
    logic                      i_rd_data;

    logic                      o_valid;
    logic                      i_ready;
    logic [X_ADR_SIZE-1:0]     o_x;
    logic [Y_ADR_SIZE-1:0]     o_y;
    logic                      o_cell_state;
    logic [NEIGHBOURS_CNT-1:0] o_nbrs;

    modport slave (
        input  i_req_valid, i_x, i_y, i_field, i_rd_data, i_ready,
        output o_req_ready, o_rd_en, o_rd_addr, o_rd_field,
               o_valid, o_x, o_y, o_cell_state, o_nbrs
    );

    modport master (
        output i_req_valid, i_x, i_y, i_field, i_rd_data, i_ready,
        input  o_req_ready, o_rd_en, o_rd_addr, o_rd_field,
               o_valid, o_x, o_y, o_cell_state, o_nbrs
    );
endinterface

// File: rtl/field_nbr_fetch.sv
// Gathers a cell and its 8 neighbours through a 1-cycle-latency single-port field RAM.
// Optional macro FIELD_TORUS_EN: edges wrap; otherwise out-of-field neighbours read as dead.
module field_nbr_fetch #(
    parameter int unsigned FIELD_W = 64,
    parameter int unsigned FIELD_H = 32
) (
    input  logic             clk,
    input  logic             rst,
    field_nbr_fetch_if.slave bus
);
    import field_nbr_fetch_pkg::*;

    localparam int unsigned X_ADR_SIZE     = $clog2(FIELD_W);
    localparam int unsigned Y_ADR_SIZE     = $clog2(FIELD_H);
    localparam int unsigned ADR_SIZE       = $clog2(FIELD_W * FIELD_H);
    localparam int unsigned NEIGHBOURS_CNT = 8;
    localparam int unsigned XW             = X_ADR_SIZE + 1;
    localparam int unsigned YW             = Y_ADR_SIZE + 1;
    localparam int unsigned KW             = 4;
    localparam int unsigned NW             = $clog2(NEIGHBOURS_CNT);

    localparam logic [KW-1:0] K_CENTRE = 4'd8;
    localparam logic [KW-1:0] K_DRAIN  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [KW-1:0]             r_k;
    logic [KW-1:0]             w_k_nxt;
    logic                      w_accept;
    logic                      w_issue;
    logic                      w_capture;
    logic [ADR_SIZE:0]         w_slot;

    logic [X_ADR_SIZE-1:0]     r_x;
    logic [Y_ADR_SIZE-1:0]     r_y;
    cur_field_t                r_rd_field;
    logic                      r_rd_en;
    logic [ADR_SIZE-1:0]       r_rd_addr;
    logic                      r_en_d;
    logic                      r_cell;
    logic [NEIGHBOURS_CNT-1:0] r_nbrs;
    logic                      w_cap_bit;

    // Returns {in_field, address} of slot k around (x, y); k=8 is the centre.
    function automatic logic [ADR_SIZE:0] slot_of(
        input logic [X_ADR_SIZE-1:0] x,
        input logic [Y_ADR_SIZE-1:0] y,
        input logic [KW-1:0]         k
    );
        logic [XW-1:0]       xe;
        logic [XW-1:0]       nx;
        logic [YW-1:0]       ye;
        logic [YW-1:0]       ny;
        logic                ok;
        logic [ADR_SIZE-1:0] addr;
        xe = {1'b0, x};
        ye = {1'b0, y};
        nx = xe;
        ny = ye;
        ok = 1'b1;
        case (k)
            4'd0, 4'd3, 4'd5: begin
                if (xe == '0) begin
`ifdef FIELD_TORUS_EN
                    nx = XW'(FIELD_W - 1);
`else
                    ok = 1'b0;
`endif
                end else begin
                    nx = xe - XW'(1);
                end
            end
            4'd2, 4'd4, 4'd7: begin
                if (xe == XW'(FIELD_W - 1)) begin
`ifdef FIELD_TORUS_EN
                    nx = '0;
`else
                    ok = 1'b0;
`endif
                end else begin
                    nx = xe + XW'(1);
                end
            end
            default: nx = xe;
        endcase
        case (k)
            4'd0, 4'd1, 4'd2: begin
                if (ye == '0) begin
`ifdef FIELD_TORUS_EN
                    ny = YW'(FIELD_H - 1);
`else
                    ok = 1'b0;
`endif
                end else begin
                    ny = ye - YW'(1);
                end
            end
            4'd5, 4'd6, 4'd7: begin
                if (ye == YW'(FIELD_H - 1)) begin
`ifdef FIELD_TORUS_EN
                    ny = '0;
`else
                    ok = 1'b0;
`endif
                end else begin
                    ny = ye + YW'(1);
                end
            end
            default: ny = ye;
        endcase
        addr = ADR_SIZE'(ny) * ADR_SIZE'(FIELD_W) + ADR_SIZE'(nx);
        return {ok, addr};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Slot k is issued in FETCH cycle k and captured in cycle k+1; cycle 9 only drains.
    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_accept    = 1'b0;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_slot      = '0;
        case (r_state)
            IDLE: begin
                if (bus.i_req_valid) begin
                    w_accept    = 1'b1;
                    w_issue     = 1'b1;
                    w_slot      = slot_of(bus.i_x, bus.i_y, '0);
                    w_k_nxt     = '0;
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_capture = (r_k != '0);
                w_k_nxt   = r_k + KW'(1);
                if (r_k < K_CENTRE) begin
                    w_issue = 1'b1;
                    w_slot  = slot_of(r_x, r_y, r_k + KW'(1));
                end
                if (r_k == K_DRAIN) begin
                    w_k_nxt     = '0;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.i_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Dead (out-of-field) slots never strobe the RAM, so their capture reads as 0.
    assign w_cap_bit = r_en_d & bus.i_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x        <= '0;
            r_y        <= '0;
            r_rd_field <= FIELD_A;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_en_d     <= 1'b0;
            r_cell     <= 1'b0;
            r_nbrs     <= '0;
        end else begin
            if (w_accept) begin
                r_x        <= bus.i_x;
                r_y        <= bus.i_y;
                r_rd_field <= bus.i_field;
            end
            r_rd_en <= w_issue & w_slot[ADR_SIZE];
            if (w_issue && w_slot[ADR_SIZE]) begin
                r_rd_addr <= w_slot[ADR_SIZE-1:0];
            end
            r_en_d <= r_rd_en;
            if (w_capture) begin
                if (r_k == K_DRAIN) begin
                    r_cell <= w_cap_bit;
                end else begin
                    r_nbrs[NW'(r_k - KW'(1))] <= w_cap_bit;
                end
            end
        end
    end

    assign bus.o_req_ready  = (r_state == IDLE);
    assign bus.o_valid      = (r_state == DONE);
    assign bus.o_rd_en      = r_rd_en;
    assign bus.o_rd_addr    = r_rd_addr;
    assign bus.o_rd_field   = r_rd_field;
    assign bus.o_x          = r_x;
    assign bus.o_y          = r_y;
    assign bus.o_cell_state = r_cell;
    assign bus.o_nbrs       = r_nbrs;

endmodule

// File: tb/tb_field_nbr_fetch.sv
// Bench for field_nbr_fetch on a 4x4 field with a two-buffer RAM model.
// Honours FIELD_TORUS_EN the same way the design does.
module tb_field_nbr_fetch;
    import field_nbr_fetch_pkg::*;

    localparam int W = 4;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    field_nbr_fetch_if #(.FIELD_W(W), .FIELD_H(H)) bus ();
    field_nbr_fetch #(.FIELD_W(W), .FIELD_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic ram_a [W*H];
    logic ram_b [W*H];

    // Synchronous-read field RAM; returns noise when not strobed.
    always @(posedge clk) begin
        if (bus.o_rd_en)
            bus.i_rd_data <= (bus.o_rd_field == FIELD_B) ? ram_b[bus.o_rd_addr] : ram_a[bus.o_rd_addr];
        else
            bus.i_rd_data <= 1'($urandom);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int dxs [9] = '{-1, 0, 1, -1, 1, -1, 0, 1, 0};
    int dys [9] = '{-1, -1, -1, 0, 0, 1, 1, 1, 0};

    bit         exp_en   [9];
    int         exp_addr [9];
    logic [7:0] exp_nb;
    logic       exp_cell;

    function automatic void model(input int x, input int y, input bit fb);
        int   nx;
        int   ny;
        bit   inr;
        logic v;
        for (int k = 0; k < 9; k++) begin
            nx  = x + dxs[k];
            ny  = y + dys[k];
            inr = (nx >= 0) && (nx < W) && (ny >= 0) && (ny < H);
`ifdef FIELD_TORUS_EN
            nx  = (nx + W) % W;
            ny  = (ny + H) % H;
            inr = 1'b1;
`endif
            exp_en[k]   = inr;
            exp_addr[k] = inr ? ny * W + nx : 0;
            v = inr ? (fb ? ram_b[exp_addr[k]] : ram_a[exp_addr[k]]) : 1'b0;
            if (k == 8) exp_cell = v;
            else        exp_nb[k] = v;
        end
    endfunction

    task automatic run_req(input int x, input int y, input bit fb, input int hold);
        int         lat;
        bit         fld_ok;
        bit         stable;
        bit         e_en;
        cur_field_t f;
        logic [7:0] snap_nb;
        logic       snap_cell;
        f = fb ? FIELD_B : FIELD_A;
        model(x, y, fb);
        @(negedge clk);
        chk("req_ready_idle", bus.o_req_ready, 1);
        bus.i_req_valid = 1'b1;
        bus.i_x = 2'(x);
        bus.i_y = 2'(y);
        bus.i_field = f;
        @(posedge clk);
        fld_ok = 1'b1;
        lat = -1;
        for (int c = 0; c < 30 && lat < 0; c++) begin
            @(negedge clk);
            // Busy-time junk on the request and result-accept lines must be ignored
            bus.i_x = 2'($urandom);
            bus.i_y = 2'($urandom);
            bus.i_field = ($urandom % 2) ? FIELD_B : FIELD_A;
            bus.i_req_valid = (c < 8) ? 1'($urandom) : 1'b0;
            bus.i_ready = (c < 8) ? 1'($urandom) : 1'b0;
            if (c <= 9) begin
                e_en = (c < 9) ? exp_en[c % 9] : 1'b0;
                chk($sformatf("rd_en_slot%0d", c), bus.o_rd_en, e_en);
                if (e_en) chk($sformatf("rd_addr_slot%0d", c), bus.o_rd_addr, exp_addr[c % 9]);
                if (bus.o_rd_field != f) fld_ok = 1'b0;
            end
            if (bus.o_valid) lat = c;
        end
        bus.i_req_valid = 1'b0;
        bus.i_ready = 1'b0;
        chk("latency", lat, 10);
        chk("rd_field", fld_ok, 1);
        chk("cell_state", bus.o_cell_state, exp_cell);
        chk("nbrs", bus.o_nbrs, exp_nb);
        chk("o_x", bus.o_x, x);
        chk("o_y", bus.o_y, y);
        chk("req_ready_done", bus.o_req_ready, 0);
        snap_nb = bus.o_nbrs;
        snap_cell = bus.o_cell_state;
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (bus.o_valid !== 1'b1 || bus.o_req_ready !== 1'b0 || bus.o_nbrs !== snap_nb ||
                bus.o_cell_state !== snap_cell || bus.o_x !== 2'(x) || bus.o_y !== 2'(y))
                stable = 1'b0;
        end
        chk("hold_stable", stable, 1);
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        chk("valid_drop", bus.o_valid, 0);
        chk("req_ready_back", bus.o_req_ready, 1);
        chk("nbrs_held", bus.o_nbrs, exp_nb);
    endtask

    task automatic reset_mid(input int x, input int y);
        model(x, y, 1'b0);
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_x = 2'(x);
        bus.i_y = 2'(y);
        bus.i_field = FIELD_A;
        @(posedge clk);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("slot4_en", bus.o_rd_en, exp_en[4]);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rd_en", bus.o_rd_en, 0);
        chk("rst_mid_valid", bus.o_valid, 0);
        chk("rst_mid_req_ready", bus.o_req_ready, 1);
        chk("rst_mid_nbrs", bus.o_nbrs, 0);
        chk("rst_mid_x", bus.o_x, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.i_req_valid = 1'b0;
        bus.i_x = '0;
        bus.i_y = '0;
        bus.i_field = FIELD_A;
        bus.i_ready = 1'b0;
        for (int i = 0; i < W * H; i++) begin
            ram_a[i] = 1'b0;
            ram_b[i] = 1'b1;
        end
        ram_a[1 * W + 1] = 1'b1;
        ram_a[1 * W + 2] = 1'b1;
        ram_a[2 * W + 1] = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.o_req_ready, 1);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_rd_en", bus.o_rd_en, 0);
        chk("rst_rd_addr", bus.o_rd_addr, 0);
        chk("rst_rd_field", bus.o_rd_field, FIELD_A);
        chk("rst_xy", {bus.o_x, bus.o_y}, 0);
        chk("rst_cell", bus.o_cell_state, 0);
        chk("rst_nbrs", bus.o_nbrs, 0);
        rst = 1'b0;

        run_req(1, 1, 1'b0, 5);
        run_req(0, 0, 1'b0, 2);
        run_req(3, 3, 1'b1, 3);
        reset_mid(2, 1);
        run_req(2, 1, 1'b0, 0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < W * H; i++) begin
                ram_a[i] = 1'($urandom);
                ram_b[i] = 1'($urandom);
            end
            run_req(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                    1'($urandom), int'($urandom_range(0, 4)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
